// File: rtl/score_keeper_pkg.sv
// Shared asteroids-game types: BCD score layout, award constants and the
// score-keeper sequencer states.
package asteroids;

  localparam int SCORE_DIGITS = 6;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [SCORE_DIGITS-1:0] score_t;

  localparam logic [8:0] PTS_SMALL  = 9'h020;
  localparam logic [8:0] PTS_MEDIUM = 9'h050;
  localparam logic [8:0] PTS_LARGE  = 9'h100;

  localparam score_t SCORE_MAX = 24'h999999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_COMMIT
  } sk_state_e;

endpackage

// File: rtl/score_keeper_if.sv
// Award/score bundle between the game logic (master) and the score keeper
// (slave).
interface score_keeper_if;
  import asteroids::*;

  logic [8:0] ast_points;
  logic       new_game;
  logic       game_over;
  score_t     score;
  score_t     high_score;
  logic       extra_life;
  logic       busy;
  logic       points_dropped;

  modport master (
    output ast_points, new_game, game_over,
    input  score, high_score, extra_life, busy, points_dropped
  );

  modport slave (
    input  ast_points, new_game, game_over,
    output score, high_score, extra_life, busy, points_dropped
  );

endinterface

// File: rtl/score_keeper_bcd_digit_add.sv
// Single-digit BCD adder; the score keeper walks it across all six digits.
module bcd_digit_add
  import asteroids::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (raw > 5'd9) begin
      sum  = raw[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Queues asteroid awards and adds them to the BCD score one digit per cycle,
// tracking high score, bonus lives and lost awards.
module score_keeper
  import asteroids::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BONUS_DIGIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_DIGIT = 3'(SCORE_DIGITS - 1);

  logic [8:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  sk_state_e  state_q, state_d;
  score_t     operand_q, operand_d;
  score_t     shadow_q, shadow_d;
  score_t     score_q, score_d;
  score_t     high_q, high_d;
  score_t     committed;
  logic       carry_q, carry_d;
  logic [2:0] digit_q, digit_d;
  logic       life_q, life_d;
  logic       dropped_q, dropped_d;

  logic       push_req, push_ok, pop;
  bcd_digit_t add_sum;
  logic       add_cout;

  bcd_digit_add u_add (
    .a    (score_q[digit_q]),
    .b    (operand_q[digit_q]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Pops only use the registered count, so a fresh push is never consumed in the same cycle.
  always_comb begin
    pop      = (state_q == S_IDLE) && (count_q != '0);
    push_req = (bus.ast_points != '0) && !bus.game_over && !bus.new_game;
    push_ok  = push_req && ((count_q != FULL_CNT) || pop);
  end

  assign committed = carry_q ? SCORE_MAX : shadow_q;

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    shadow_d  = shadow_q;
    score_d   = score_q;
    high_d    = high_q;
    carry_d   = carry_q;
    digit_d   = digit_q;
    life_d    = 1'b0;
    dropped_d = dropped_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          operand_d = score_t'({15'd0, fifo_q[rd_ptr_q]});
          carry_d   = 1'b0;
          digit_d   = 3'd0;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        shadow_d[digit_q] = add_sum;
        carry_d           = add_cout;
        digit_d           = digit_q + 3'd1;
        if (digit_q == LAST_DIGIT) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        score_d = committed;
        life_d  = (committed[BONUS_DIGIT] != score_q[BONUS_DIGIT]);
        if (committed > high_q) begin
          high_d = committed;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      dropped_d = 1'b1;
    end

    // A new game abandons everything in flight but keeps the high score.
    if (bus.new_game) begin
      score_d   = '0;
      high_d    = high_q;
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = 1'b0;
      life_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      shadow_q  <= '0;
      score_q   <= '0;
      high_q    <= '0;
      carry_q   <= 1'b0;
      digit_q   <= 3'd0;
      life_q    <= 1'b0;
      dropped_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      shadow_q  <= shadow_d;
      score_q   <= score_d;
      high_q    <= high_d;
      carry_q   <= carry_d;
      digit_q   <= digit_d;
      life_q    <= life_d;
      dropped_q <= dropped_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_q[wr_ptr_q] <= bus.ast_points;
    end
  end

  assign bus.score          = score_q;
  assign bus.high_score     = high_q;
  assign bus.extra_life     = life_q;
  assign bus.points_dropped = dropped_q;
  assign bus.busy           = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a cycle-timed decimal model predicts each
// committed score, and a monitor checks every score change against it.
module tb_score_keeper;
  import asteroids::*;

  localparam int DEPTH     = 4;
  localparam int BONUS     = 4;
  localparam int MAX_SCORE = 999999;

  logic clk;
  logic reset;
  int   cyc;
  int   testsRun;
  int   testsFailed;
  bit   presetting;

  score_keeper_if sk_if ();

  score_keeper #(.FIFO_DEPTH(DEPTH), .BONUS_DIGIT(BONUS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sk_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted awards with the edges at which they leave the queue and land in the score.
  typedef struct {
    int popE;
    int commitE;
    int score;
    int high;
  } award_t;

  typedef struct {
    int          edgeNo;
    logic [23:0] score;
    logic [23:0] high;
    logic        life;
  } expect_t;

  award_t  acc[$];
  expect_t expQ[$];
  int      baseScore;
  int      baseHigh;
  int      lastCommit;
  bit      mDropped;

  function automatic logic [23:0] toBcd(input int v);
    logic [23:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ptsDec(input logic [8:0] p);
    return int'(p[8]) * 100 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic int bonusDigit(input int v);
    return (v / (10 ** BONUS)) % 10;
  endfunction

  function automatic int tailScore();
    return (acc.size() > 0) ? acc[acc.size()-1].score : baseScore;
  endfunction

  function automatic int tailHigh();
    return (acc.size() > 0) ? acc[acc.size()-1].high : baseHigh;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, sampled by the DUT at edge cyc+1; the model is advanced for that edge.
  task automatic applyStimulus(input logic [8:0] pts, input bit ng, input bit go, input bit rst);
    int k, sc, hi, inQueue, popE, prev, prevHi, nxt;
    @(negedge clk);
    reset               = rst;
    sk_if.ast_points    = pts;
    sk_if.new_game      = ng;
    sk_if.game_over     = go;
    k = cyc + 1;
    if (rst) begin
      acc.delete();
      expQ.delete();
      baseScore  = 0;
      baseHigh   = 0;
      lastCommit = 0;
      mDropped   = 1'b0;
    end else if (ng) begin
      sc = baseScore;
      hi = baseHigh;
      foreach (acc[i]) begin
        if (acc[i].commitE < k) begin
          sc = acc[i].score;
          hi = acc[i].high;
        end
      end
      expQ.delete();
      if (sc != 0) expQ.push_back('{k, 24'h0, toBcd(hi), 1'b0});
      acc.delete();
      baseScore  = 0;
      baseHigh   = hi;
      lastCommit = 0;
      mDropped   = 1'b0;
    end else if (pts != '0 && !go) begin
      inQueue = 0;
      foreach (acc[i]) if (acc[i].popE > k) inQueue++;
      if (inQueue >= DEPTH) begin
        mDropped = 1'b1;
      end else begin
        popE   = (k + 1 > lastCommit + 1) ? k + 1 : lastCommit + 1;
        prev   = tailScore();
        prevHi = tailHigh();
        nxt    = prev + ptsDec(pts);
        if (nxt > MAX_SCORE) nxt = MAX_SCORE;
        if (nxt > prevHi) prevHi = nxt;
        acc.push_back('{popE, popE + 7, nxt, prevHi});
        lastCommit = popE + 7;
        if (nxt != prev)
          expQ.push_back('{popE + 7, toBcd(nxt), toBcd(prevHi), logic'(bonusDigit(nxt) != bonusDigit(prev))});
      end
    end
  endtask

  task automatic feed(input logic [8:0] pts);
    applyStimulus(pts, 1'b0, 1'b0, 1'b0);
    repeat (7) applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkIdle(input string tag);
    for (int i = 0; i < 400 && cyc <= lastCommit + 1; i++)
      applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_busy"}, 32'(sk_if.busy), 32'd0);
    checkOutput({tag, "_score"}, 32'(sk_if.score), 32'(toBcd(tailScore())));
    checkOutput({tag, "_high"}, 32'(sk_if.high_score), 32'(toBcd(tailHigh())));
    checkOutput({tag, "_dropped"}, 32'(sk_if.points_dropped), 32'(mDropped));
  endtask

  // Monitor: every score change must match the next expectation, at the predicted edge.
  initial begin
    logic [23:0] prevScore;
    expect_t     e;
    prevScore = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!(reset || presetting)) begin
        if (sk_if.score !== prevScore) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_score_change", 32'(sk_if.score), 32'(prevScore));
          end else begin
            e = expQ.pop_front();
            checkOutput("commit_edge", 32'(cyc), 32'(e.edgeNo));
            checkOutput("score", 32'(sk_if.score), 32'(e.score));
            checkOutput("high_score", 32'(sk_if.high_score), 32'(e.high));
            checkOutput("extra_life", 32'(sk_if.extra_life), 32'(e.life));
          end
        end else begin
          checkOutput("extra_life_quiet", 32'(sk_if.extra_life), 32'd0);
        end
      end
      prevScore = sk_if.score;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] pts;
    int         r;
    cyc              = 0;
    testsRun         = 0;
    testsFailed      = 0;
    presetting       = 1'b0;
    reset            = 1'b1;
    sk_if.ast_points = '0;
    sk_if.new_game   = 1'b0;
    sk_if.game_over  = 1'b0;

    repeat (3) applyStimulus(9'h000, 1'b0, 1'b0, 1'b1);
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_score", 32'(sk_if.score), 32'd0);
    checkOutput("reset_high", 32'(sk_if.high_score), 32'd0);
    checkOutput("reset_busy", 32'(sk_if.busy), 32'd0);
    checkOutput("reset_life", 32'(sk_if.extra_life), 32'd0);

    $display("[TB] single award");
    applyStimulus(PTS_MEDIUM, 1'b0, 1'b0, 1'b0);
    checkIdle("single");

    $display("[TB] burst of four");
    applyStimulus(PTS_SMALL, 1'b0, 1'b0, 1'b0);
    applyStimulus(PTS_MEDIUM, 1'b0, 1'b0, 1'b0);
    applyStimulus(PTS_LARGE, 1'b0, 1'b0, 1'b0);
    applyStimulus(PTS_LARGE, 1'b0, 1'b0, 1'b0);
    checkIdle("burst");

    $display("[TB] queue overflow");
    applyStimulus(9'h000, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(PTS_LARGE, 1'b0, 1'b0, 1'b0);
    checkIdle("overflow");
    checkOutput("overflow_score_500", 32'(sk_if.score), 32'h000500);

    $display("[TB] bonus life at 10000");
    applyStimulus(9'h000, 1'b1, 1'b0, 1'b0);
    repeat (99) feed(PTS_LARGE);
    repeat (4) feed(PTS_SMALL);
    checkIdle("preset9980");
    feed(PTS_SMALL);
    checkIdle("bonus");
    checkOutput("bonus_score_10000", 32'(sk_if.score), 32'h010000);

    $display("[TB] saturation");
    presetting = 1'b1;
    @(negedge clk);
    force dut.score_q = 24'h999980;
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    release dut.score_q;
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    presetting = 1'b0;
    acc.delete();
    baseScore = 999980;
    feed(PTS_LARGE);
    feed(PTS_LARGE);
    checkIdle("saturate");
    checkOutput("saturate_score", 32'(sk_if.score), 32'h999999);

    $display("[TB] new game mid-add");
    applyStimulus(9'h000, 1'b1, 1'b0, 1'b0);
    feed(PTS_MEDIUM);
    repeat (3) applyStimulus(PTS_SMALL, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    applyStimulus(PTS_LARGE, 1'b1, 1'b0, 1'b0);
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    checkOutput("ng_busy", 32'(sk_if.busy), 32'd0);
    checkOutput("ng_score", 32'(sk_if.score), 32'd0);
    checkOutput("ng_high", 32'(sk_if.high_score), 32'h999999);
    checkIdle("newgame");

    $display("[TB] game over ignores awards");
    feed(PTS_MEDIUM);
    repeat (3) applyStimulus(PTS_LARGE, 1'b0, 1'b1, 1'b0);
    checkIdle("gameover");

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      r   = $urandom_range(0, 9);
      pts = (r < 6) ? 9'h000 : (r < 7) ? PTS_SMALL : (r < 8) ? PTS_MEDIUM : PTS_LARGE;
      applyStimulus(pts, ($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0), 1'b0);
    end
    checkIdle("random");

    $display("[TB] reset with new game");
    repeat (6) applyStimulus(PTS_LARGE, 1'b0, 1'b0, 1'b0);
    applyStimulus(PTS_LARGE, 1'b1, 1'b0, 1'b1);
    applyStimulus(9'h000, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ng_score", 32'(sk_if.score), 32'd0);
    checkOutput("rst_ng_high", 32'(sk_if.high_score), 32'd0);
    checkOutput("rst_ng_busy", 32'(sk_if.busy), 32'd0);
    checkOutput("rst_ng_life", 32'(sk_if.extra_life), 32'd0);
    checkOutput("rst_ng_dropped", 32'(sk_if.points_dropped), 32'd0);
    checkIdle("final");

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of pending point entries; power of two, minimum 2.
REQ-002 Parameter BONUS_DIGIT, default 4: BCD digit index (0 = units) whose change awards an extra life; 4 means one life per 10000 points.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ast_points  in  9  BCD award from the asteroid blocks; 9'h000 means no hit, legal non-zero values are 9'h020, 9'h050 and 9'h100; valid for one cycle.
REQ-006 new_game  in  1  one-cycle pulse that starts a new game.
REQ-007 game_over  in  1  level; high means awards are ignored.
REQ-008 score  out  24  current score, 6 packed BCD digits.
REQ-009 high_score  out  24  best score since reset, 6 packed BCD digits.
REQ-010 extra_life  out  1  one-cycle pulse per bonus threshold crossed.
REQ-011 busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE.
REQ-012 points_dropped  out  1  sticky flag: an award was lost because the FIFO was full.

Function
REQ-013 Push: ast_points != 0, game_over = 0 and new_game = 0 push ast_points into the FIFO at that edge.
REQ-014 Full FIFO: a push is accepted if a pop happens at the same edge; otherwise the award is discarded and points_dropped is set.
REQ-015 There is no bypass path; a pushed entry can be popped no earlier than the next edge.
REQ-016 FSM states are IDLE, ADD and COMMIT.
REQ-017 IDLE: with the FIFO non-empty, pop the entry into a 24-bit operand (zero-extended), clear the carry, set the digit index to 0, and go to ADD.
REQ-018 ADD: each cycle, add one BCD digit of score and operand plus carry into a shadow register, then increment the digit index. After digit 5, go to COMMIT.
REQ-019 COMMIT: write the shadow register to score. If the final carry is 1, write 24'h999999 instead (saturation). Then return to IDLE.
REQ-020 Latency: an award sampled at edge k updates score at edge k+8 when the FIFO is empty and the FSM is IDLE. Throughput is one award per 8 cycles.
REQ-021 extra_life pulses at the cycle after COMMIT if digit BONUS_DIGIT of the committed value differs from the previous score; no pulse when saturated score is unchanged.
REQ-022 high_score is loaded with the committed value at COMMIT when that value is strictly greater (packed-BCD compare is equivalent to unsigned compare).
REQ-023 game_over high: no pushes; an in-flight add and queued entries still complete.
REQ-024 new_game in any state has these effects at the next edge: score = 0, FIFO emptied, FSM to IDLE, points_dropped = 0, extra_life = 0. high_score is kept, and a concurrent award is dropped.
REQ-025 BCD digit add: sum = a + b + cin. If sum > 9, digit = sum + 6 (mod 16) and cout = 1. Inputs are always valid BCD.

Reset
REQ-026 reset forces score = 0, high_score = 0, FIFO empty, FSM IDLE, extra_life = 0, points_dropped = 0, busy = 0.
REQ-027 reset takes precedence over new_game and ast_points in the same cycle.

Structure
REQ-028 The shared package asteroids holds constant SCORE_DIGITS = 6, typedef bcd_digit_t (4 bits) and typedef score_t (SCORE_DIGITS x bcd_digit_t), plus the point constants 9'h020, 9'h050 and 9'h100.
REQ-029 One combinational sub-module, bcd_digit_add (a, b, cin -> sum, cout), is instantiated once and time-shared across digits.

Verification
REQ-030 Single award: after reset, ast_points = 9'h050 for 1 cycle -> score = 24'h000050 exactly 8 cycles later, high_score = 24'h000050, busy low afterwards.
REQ-031 Burst: 9'h020, 9'h050, 9'h100, 9'h100 on consecutive cycles -> final score 24'h000270, points_dropped = 0.
REQ-032 Overflow: 6 consecutive 9'h100 awards with FIFO_DEPTH = 4 -> points_dropped = 1 and score = 24'h000500 (one award is popped before the FIFO fills, so only one is dropped).
REQ-033 Bonus and carry: score preset to 24'h009980 via awards, then 9'h020 -> score 24'h010000 with a single extra_life pulse. Same test from 24'h999980 plus 9'h100 -> score 24'h999999 (saturated).
REQ-034 new_game mid-ADD with 2 entries queued -> score = 0, busy = 0 next cycle, high_score unchanged.
REQ-035 game_over high with awards applied -> score unchanged; reset asserted together with new_game -> every output at its reset value.
